// File: rtl/fir_decimate_uv_pkg.sv
// Shared constants and types for the 2:1 U/V chroma decimator.
// Coefficients, rounding/shift, FSM state and MAC tap-select encodings, clip helper.
package fir_decim_pkg;

    // Symmetric 11-tap kernel; the -52 pair is stored with its sign applied
    localparam logic signed [9:0]  COEF_P5   = 10'sd21;
    localparam logic signed [9:0]  COEF_P3   = -10'sd52;
    localparam logic signed [9:0]  COEF_P1   = 10'sd159;
    localparam logic signed [9:0]  COEF_C    = 10'sd256;
    localparam logic signed [31:0] ACC_ROUND = 32'sd256;
    localparam int                 ACC_SHIFT = 9;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FLUSH = 3'd2,
        S_MAC   = 3'd3,
        S_OUT_U = 3'd4,
        S_OUT_V = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        TAP_P5 = 2'd0,
        TAP_P3 = 2'd1,
        TAP_P1 = 2'd2,
        TAP_C  = 2'd3
    } tap_t;

    // {saturated, clipped byte}
    function automatic logic [8:0] clip_u8(input logic signed [31:0] v);
        logic [8:0] r;
        if (v < 32'sd0) begin
            r = {1'b1, 8'h00};
        end else if (v > 32'sd255) begin
            r = {1'b1, 8'hFF};
        end else begin
            r = {1'b0, v[7:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_decimate_uv_if.sv
// Pixel-in / packed-word-out handshake bundle of the chroma decimator.
// slave: the decimator side; master: the upstream converter + SRAM arbiter side.
interface fir_decimate_uv_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sol;
    logic [7:0]  in_u;
    logic [7:0]  in_v;
    logic        out_valid;
    logic        out_ready;
    logic        out_is_v;
    logic [15:0] out_data;
    logic        line_done;
    logic        busy;

    modport slave (
        input  in_valid, in_sol, in_u, in_v, out_ready,
        output in_ready, out_valid, out_is_v, out_data, line_done, busy
    );

    modport master (
        output in_valid, in_sol, in_u, in_v, out_ready,
        input  in_ready, out_valid, out_is_v, out_data, line_done, busy
    );
endinterface

// File: rtl/fir_decimate_uv_mac.sv
// Shared multiply-accumulate for one output sample: tap-pair add, one multiplier,
// accumulator seeded with the rounding constant on start, final shift and clip.
module fir_decim_mac
    import fir_decim_pkg::*;
(
    input  logic       CLOCK_50_I,
    input  logic       reset,
    input  tap_t       tap_sel,
    input  logic       start,
    input  logic [7:0] tap_a,
    input  logic [7:0] tap_b,
    output logic [7:0] y,
    output logic       sat
);

    logic [8:0]         pair_s;
    logic signed [9:0]  coef_s;
    logic signed [31:0] prod_s;
    logic signed [31:0] acc_next_s;
    logic signed [31:0] acc_r;
    logic [8:0]         clip_s;

    // Coefficient select, product and running sum; y/sat are meaningful on the centre tap
    always_comb begin
        pair_s = {1'b0, tap_a} + {1'b0, tap_b};
        case (tap_sel)
            TAP_P5:  coef_s = COEF_P5;
            TAP_P3:  coef_s = COEF_P3;
            TAP_P1:  coef_s = COEF_P1;
            TAP_C:   coef_s = COEF_C;
            default: coef_s = COEF_C;
        endcase
        prod_s = $signed({23'd0, pair_s}) * $signed({{22{coef_s[9]}}, coef_s});
        if (start) begin
            acc_next_s = ACC_ROUND + prod_s;
        end else begin
            acc_next_s = acc_r + prod_s;
        end
        clip_s = clip_u8(acc_next_s >>> ACC_SHIFT);
        y      = clip_s[7:0];
        sat    = clip_s[8];
    end

    // Accumulator register
    always_ff @(posedge CLOCK_50_I) begin
        if (reset) begin
            acc_r <= 32'sd0;
        end else begin
            acc_r <= acc_next_s;
        end
    end

endmodule

// File: rtl/fir_decimate_uv.sv
// 2:1 chroma decimator: 11-tap FIR on U and V, two samples packed per 16-bit word.
// Optional FIR_DECIM_SAT_CNT_EN adds a saturating clip counter output sat_count.
module fir_decimate_uv
    import fir_decim_pkg::*;
#(
    parameter int LINE_W = 320
) (
    input  logic              CLOCK_50_I,
    input  logic              reset,
    fir_decimate_uv_if.slave  bus
`ifdef FIR_DECIM_SAT_CNT_EN
    ,
    output logic [15:0]       sat_count
`endif
);

    localparam int PC_W = $clog2(LINE_W + 8);
    localparam int J_W  = $clog2(LINE_W / 2 + 1);
    localparam logic [J_W-1:0]  J_LAST  = J_W'(LINE_W / 2 - 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(LINE_W - 1);
    localparam logic [PC_W-1:0] PC_END  = PC_W'(LINE_W);

    state_t          state_r;
    logic [7:0]      win_u_r [11];
    logic [7:0]      win_v_r [11];
    logic [PC_W-1:0] pc_r;
    logic [J_W-1:0]  j_r;
    logic [2:0]      mac_cnt_r;
    logic [15:0]     u_pack_r;
    logic [15:0]     v_pack_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            out_is_v_r;
    logic [15:0]     out_data_r;
    logic            line_done_r;
    logic            busy_r;

    logic            in_xfer_s;
    logic            out_xfer_s;
    logic [PC_W-1:0] target_s;
    logic            input_done_s;
    tap_t            tap_sel_s;
    logic            plane_v_s;
    logic [7:0]      tap_a_s;
    logic [7:0]      tap_b_s;
    logic [7:0]      mac_y_s;
    logic            mac_sat_s;

    assign in_xfer_s    = bus.in_valid & in_ready_r;
    assign out_xfer_s   = out_valid_r & bus.out_ready;
    // pc_r is the index of the next sample to enter tap 10; window for j is full once x[2j+5] is in
    assign target_s     = PC_W'({j_r, 1'b0}) + PC_W'(3'd5);
    assign input_done_s = (pc_r >= PC_END);

    // MAC operand routing: counter bits [1:0] pick the tap pair, bit 2 the plane
    always_comb begin
        tap_sel_s = tap_t'(mac_cnt_r[1:0]);
        plane_v_s = mac_cnt_r[2];
        case (tap_sel_s)
            TAP_P5: begin
                tap_a_s = plane_v_s ? win_v_r[0]  : win_u_r[0];
                tap_b_s = plane_v_s ? win_v_r[10] : win_u_r[10];
            end
            TAP_P3: begin
                tap_a_s = plane_v_s ? win_v_r[2]  : win_u_r[2];
                tap_b_s = plane_v_s ? win_v_r[8]  : win_u_r[8];
            end
            TAP_P1: begin
                tap_a_s = plane_v_s ? win_v_r[4]  : win_u_r[4];
                tap_b_s = plane_v_s ? win_v_r[6]  : win_u_r[6];
            end
            TAP_C: begin
                tap_a_s = plane_v_s ? win_v_r[5]  : win_u_r[5];
                tap_b_s = 8'd0;
            end
            default: begin
                tap_a_s = 8'd0;
                tap_b_s = 8'd0;
            end
        endcase
    end

    fir_decim_mac u_mac (
        .CLOCK_50_I (CLOCK_50_I),
        .reset      (reset),
        .tap_sel    (tap_sel_s),
        .start      (mac_cnt_r[1:0] == 2'd0),
        .tap_a      (tap_a_s),
        .tap_b      (tap_b_s),
        .y          (mac_y_s),
        .sat        (mac_sat_s)
    );

    // Line sequencer: window fill, MAC schedule, packing and output handshake
    always_ff @(posedge CLOCK_50_I) begin
        if (reset) begin
            state_r     <= S_IDLE;
            for (int i = 0; i < 11; i++) begin
                win_u_r[i] <= 8'd0;
                win_v_r[i] <= 8'd0;
            end
            pc_r        <= '0;
            j_r         <= '0;
            mac_cnt_r   <= 3'd0;
            u_pack_r    <= 16'd0;
            v_pack_r    <= 16'd0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_is_v_r  <= 1'b0;
            out_data_r  <= 16'd0;
            line_done_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            line_done_r <= 1'b0;
            // Start of line (also aborts a line in S_LOAD): x[0] replicated across the window
            if (in_xfer_s && bus.in_sol) begin
                for (int i = 0; i < 11; i++) begin
                    win_u_r[i] <= bus.in_u;
                    win_v_r[i] <= bus.in_v;
                end
                pc_r       <= PC_W'(1'b1);
                j_r        <= '0;
                u_pack_r   <= 16'd0;
                v_pack_r   <= 16'd0;
                busy_r     <= 1'b1;
                in_ready_r <= 1'b1;
                state_r    <= S_LOAD;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end
                    S_LOAD, S_FLUSH: begin
                        if (in_xfer_s || (state_r == S_FLUSH)) begin
                            for (int i = 0; i < 10; i++) begin
                                win_u_r[i] <= win_u_r[i+1];
                                win_v_r[i] <= win_v_r[i+1];
                            end
                            // Past the line end, tap 10 already holds x[LINE_W-1]
                            win_u_r[10] <= (state_r == S_FLUSH) ? win_u_r[10] : bus.in_u;
                            win_v_r[10] <= (state_r == S_FLUSH) ? win_v_r[10] : bus.in_v;
                            pc_r        <= pc_r + PC_W'(1'b1);
                            if (pc_r == target_s) begin
                                state_r    <= S_MAC;
                                mac_cnt_r  <= 3'd0;
                                in_ready_r <= 1'b0;
                            end else if (pc_r == PC_LAST) begin
                                state_r    <= S_FLUSH;
                                in_ready_r <= 1'b0;
                            end
                        end
                    end
                    S_MAC: begin
                        mac_cnt_r <= mac_cnt_r + 3'd1;
                        if (mac_cnt_r[1:0] == 2'd3) begin
                            if (!plane_v_s && j_r[0]) begin
                                u_pack_r[7:0] <= mac_y_s;
                            end else if (!plane_v_s) begin
                                u_pack_r[15:8] <= mac_y_s;
                            end else if (j_r[0]) begin
                                v_pack_r[7:0] <= mac_y_s;
                            end else begin
                                v_pack_r[15:8] <= mac_y_s;
                            end
                        end
                        if (mac_cnt_r == 3'd7) begin
                            if (j_r[0]) begin
                                state_r     <= S_OUT_U;
                                out_valid_r <= 1'b1;
                                out_is_v_r  <= 1'b0;
                                out_data_r  <= u_pack_r;
                            end else begin
                                j_r        <= j_r + J_W'(1'b1);
                                state_r    <= input_done_s ? S_FLUSH : S_LOAD;
                                in_ready_r <= ~input_done_s;
                            end
                        end
                    end
                    S_OUT_U: begin
                        if (out_xfer_s) begin
                            out_data_r <= v_pack_r;
                            out_is_v_r <= 1'b1;
                            state_r    <= S_OUT_V;
                        end
                    end
                    S_OUT_V: begin
                        if (out_xfer_s) begin
                            out_valid_r <= 1'b0;
                            out_is_v_r  <= 1'b0;
                            if (j_r == J_LAST) begin
                                line_done_r <= 1'b1;
                                busy_r      <= 1'b0;
                                in_ready_r  <= 1'b1;
                                state_r     <= S_IDLE;
                            end else begin
                                j_r        <= j_r + J_W'(1'b1);
                                state_r    <= input_done_s ? S_FLUSH : S_LOAD;
                                in_ready_r <= ~input_done_s;
                            end
                        end
                    end
                    default: begin
                        state_r     <= S_IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef FIR_DECIM_SAT_CNT_EN
    logic [15:0] sat_count_r;

    // Clip event counter, sticks at all-ones
    always_ff @(posedge CLOCK_50_I) begin
        if (reset) begin
            sat_count_r <= 16'd0;
        end else if ((state_r == S_MAC) && (mac_cnt_r[1:0] == 2'd3) && mac_sat_s
                     && (sat_count_r != 16'hFFFF)) begin
            sat_count_r <= sat_count_r + 16'd1;
        end else begin
            sat_count_r <= sat_count_r;
        end
    end

    assign sat_count = sat_count_r;
`else
    logic sat_unused_s;
    assign sat_unused_s = mac_sat_s;
`endif

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_is_v  = out_is_v_r;
    assign bus.out_data  = out_data_r;
    assign bus.line_done = line_done_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_fir_decimate_uv.sv
// Scoreboard bench for fir_decimate_uv at LINE_W=16; sat_count checked when
// FIR_DECIM_SAT_CNT_EN is defined.
module tb_fir_decimate_uv;

    localparam int LW = 16;
    typedef logic [7:0] line_t [LW];
    typedef struct packed {
        logic        is_v;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    fir_decimate_uv_if bus();
`ifdef FIR_DECIM_SAT_CNT_EN
    logic [15:0] sat_count;
`endif

    fir_decimate_uv #(.LINE_W(LW)) dut (
        .CLOCK_50_I (clk),
        .reset      (reset),
        .bus        (bus)
`ifdef FIR_DECIM_SAT_CNT_EN
        ,
        .sat_count  (sat_count)
`endif
    );

    int          errors = 0;
    int          checks = 0;
    exp_t        exp_q[$];
    int          ld_cnt = 0;
    int          widx = 0;
    int          exp_sat = 0;
    logic [15:0] capt_u [LW/4];
    logic [15:0] capt_v [LW/4];
    line_t       lu, lv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int px(input line_t x, input int i);
        int k;
        k = (i < 0) ? 0 : ((i > LW - 1) ? LW - 1 : i);
        return int'(x[k]);
    endfunction

    // Reference filter: returns {clipped, y}
    function automatic logic [8:0] golden(input line_t x, input int j);
        int c, acc, y;
        c   = 2 * j;
        acc = 21 * (px(x, c-5) + px(x, c+5)) - 52 * (px(x, c-3) + px(x, c+3))
            + 159 * (px(x, c-1) + px(x, c+1)) + 256 * px(x, c) + 256;
        y   = acc >>> 9;
        if (y < 0) return {1'b1, 8'h00};
        else if (y > 255) return {1'b1, 8'hFF};
        else return {1'b0, y[7:0]};
    endfunction

    task automatic push_line(input line_t u, input line_t v);
        logic [8:0] a, b, c, d;
        exp_t e;
        for (int k = 0; k < LW / 4; k++) begin
            a = golden(u, 2*k); b = golden(u, 2*k+1);
            c = golden(v, 2*k); d = golden(v, 2*k+1);
            exp_sat += int'(a[8]) + int'(b[8]) + int'(c[8]) + int'(d[8]);
            e.is_v = 1'b0; e.data = {a[7:0], b[7:0]}; exp_q.push_back(e);
            e.is_v = 1'b1; e.data = {c[7:0], d[7:0]}; exp_q.push_back(e);
        end
    endtask

    // Called and returns at posedge+1
    task automatic send_px(input logic [7:0] u, input logic [7:0] v, input logic sol);
        int n;
        n = 0;
        bus.in_valid = 1'b1; bus.in_u = u; bus.in_v = v; bus.in_sol = sol;
        @(negedge clk);
        while (!bus.in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("in_accept_timeout", 32'(n < 500), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_sol = 1'b0;
    endtask

    task automatic send_range(input line_t u, input line_t v, input int first, input int last,
                              input logic sol_first);
        for (int i = first; i <= last; i++) begin
            send_px(u[i], v[i], sol_first && (i == first));
        end
    endtask

    task automatic wait_line(input int target);
        int n;
        n = 0;
        while (ld_cnt < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("line_done_count", 32'(ld_cnt), 32'(target));
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Output monitor: pops the scoreboard on every word transfer
    always @(negedge clk) begin
        exp_t e;
        if (bus.line_done === 1'b1) ld_cnt++;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            check("word_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("word_is_v", 32'(bus.out_is_v), 32'(e.is_v));
                check("word_data", 32'(bus.out_data), 32'(e.data));
            end
            if (widx < LW / 4) begin
                if (bus.out_is_v) begin
                    capt_v[widx] = bus.out_data;
                    widx++;
                end else begin
                    capt_u[widx] = bus.out_data;
                end
            end
        end
    end

    initial begin
        int n;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_sol = 1'b0; bus.in_u = 8'd0; bus.in_v = 8'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_is_v", 32'(bus.out_is_v), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_line_done", 32'(bus.line_done), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
`ifdef FIR_DECIM_SAT_CNT_EN
        check("rst_sat_count", 32'(sat_count), 32'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        // 1: constant line
        for (int i = 0; i < LW; i++) begin lu[i] = 8'd100; lv[i] = 8'd50; end
        widx = 0; push_line(lu, lv);
        send_range(lu, lv, 0, LW - 1, 1'b1);
        wait_line(1);
        check("const_u0", 32'(capt_u[0]), 32'h6464);
        check("const_v3", 32'(capt_v[3]), 32'h3232);

        // 2: ramp
        for (int i = 0; i < LW; i++) begin lu[i] = 8'(i); lv[i] = 8'(200 - 3 * i); end
        widx = 0; push_line(lu, lv);
        send_range(lu, lv, 0, LW - 1, 1'b1);
        wait_line(2);
        check("ramp_y0", 32'(capt_u[0][15:8]), 32'd0);
        check("ramp_y3", 32'(capt_u[1][7:0]), 32'd6);
        check("ramp_y4_y5", 32'(capt_u[2]), 32'h080A);

        // 3: clip high on U j=4, clip low on V j=4
        for (int i = 0; i < LW; i++) begin lu[i] = 8'd128; lv[i] = 8'd128; end
        lu[3] = 8'd255; lu[5] = 8'd0;   lu[7] = 8'd255; lu[8] = 8'd255;
        lu[9] = 8'd255; lu[11] = 8'd0;  lu[13] = 8'd255;
        lv[3] = 8'd0;   lv[5] = 8'd255; lv[7] = 8'd0;   lv[8] = 8'd0;
        lv[9] = 8'd0;   lv[11] = 8'd255; lv[13] = 8'd0;
        widx = 0; push_line(lu, lv);
        send_range(lu, lv, 0, LW - 1, 1'b1);
        wait_line(3);
        check("clip_high", 32'(capt_u[2][15:8]), 32'hFF);
        check("clip_low", 32'(capt_v[2][15:8]), 32'h00);
`ifdef FIR_DECIM_SAT_CNT_EN
        check("sat_count", 32'(sat_count), 32'(exp_sat));
`endif

        // 4: backpressure in S_OUT_U
        for (int i = 0; i < LW; i++) begin lu[i] = 8'(i * 13 + 40); lv[i] = 8'(200 - i * 7); end
        widx = 0; push_line(lu, lv);
        bus.out_ready = 1'b0;
        send_range(lu, lv, 0, 7, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        repeat (20) begin
            @(negedge clk);
            check("bp_hold_data", 32'(bus.out_data), 32'(exp_q[0].data));
            check("bp_hold_is_v", 32'(bus.out_is_v), 32'd0);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send_range(lu, lv, 8, LW - 1, 1'b0);
        wait_line(4);

        // 5: in_sol at pixel 7 aborts the partial line
        for (int i = 0; i < LW; i++) begin lu[i] = 8'd77; lv[i] = 8'd33; end
        send_range(lu, lv, 0, 6, 1'b1);
        for (int i = 0; i < LW; i++) begin lu[i] = 8'((i * 37 + 11) % 256); lv[i] = 8'(255 - i * 19); end
        widx = 0; push_line(lu, lv);
        send_range(lu, lv, 0, LW - 1, 1'b1);
        wait_line(5);

        // 6: reset while in S_MAC
        for (int i = 0; i < LW; i++) begin lu[i] = 8'd90; lv[i] = 8'd140; end
        send_range(lu, lv, 0, 5, 1'b1);
        @(negedge clk);
        check("mac_busy", 32'(bus.busy), 32'd1);
        check("mac_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_sat = 0;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
`ifdef FIR_DECIM_SAT_CNT_EN
        check("mid_rst_sat_count", 32'(sat_count), 32'd0);
`endif
        @(posedge clk); #1;
        for (int i = 0; i < LW; i++) begin lu[i] = 8'((i * 61 + 5) % 256); lv[i] = 8'((i * i * 7) % 256); end
        widx = 0; push_line(lu, lv);
        send_range(lu, lv, 0, LW - 1, 1'b1);
        wait_line(6);
`ifdef FIR_DECIM_SAT_CNT_EN
        check("final_sat_count", 32'(sat_count), 32'(exp_sat));
`endif

        repeat (10) @(posedge clk);
        @(negedge clk);
        check("total_line_done", 32'(ld_cnt), 32'd6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
